chimera_clu_gate_seq: RTL
=========================

# chimera_clu_gate_seq

Per-cluster clock-gating sequencer that sits between the top-level register file's cluster clock-gate enable fields and the cluster clock gates feeding the cluster domain. For each cluster it turns a static "gate requested" bit into a safe sequence:

- isolate the cluster's AXI ports;
- wait until outstanding transactions have drained;
- stop the clock;
- on release, restart the clock, let it settle, then lift isolation.

It drives the gate cells' enable, the AXI isolation requests, and a status/error vector back to the register file.

## Interface

Parameters:
- NumClusters, 5, number of independent clusters (one FSM each).
- TimeoutCycles, 1024, maximum cycles spent in ISOLATE waiting for drain acknowledge; must be >= 1.
- SettleCycles, 4, cycles the clock runs with isolation held after ungating; must be >= 1.

Ports:
- soc_clk_i  in  1  SoC clock; all state is in this domain.
- rst_ni  in  1  Reset, asynchronous, active-low.
- gate_req_i  in  NumClusters  1 = software requests cluster clock off (level, from register file).
- isolated_i  in  NumClusters  1 = cluster AXI isolation complete, no outstanding transactions.
- isolate_o  out  NumClusters  1 = isolate cluster AXI ports.
- clk_en_o  out  NumClusters  enable to cluster clock gate; 1 = clock running.
- gated_o  out  NumClusters  status, 1 = cluster clock currently stopped.
- timeout_o  out  NumClusters  one-cycle pulse, drain timeout abort.

## Operation

- There are NumClusters identical, fully independent FSMs. All outputs are registered and decoded from state (Moore).
- Each cluster has one shared counter, width $clog2(max(TimeoutCycles,SettleCycles)+1). The counter clears on every state change and saturates.
- Each cluster has a `blocked` flag, set on timeout abort and cleared when gate_req_i is low.

States, with outputs listed as (isolate_o, clk_en_o, gated_o):

- **RUN** (0,1,0)
  - gate_req_i=1 and not blocked -> ISOLATE.
- **ISOLATE** (1,1,0). Evaluated in this priority:
  1. gate_req_i=0 -> RUN (request withdrawal wins over everything).
  2. isolated_i=1 -> GATED.
  3. counter == TimeoutCycles-1 -> RUN, pulse timeout_o, set blocked.
  4. Otherwise increment the counter.
  - If isolated_i and the timeout occur in the same cycle, isolated_i wins.
- **GATED** (1,0,1)
  - gate_req_i=0 -> WAKE.
  - isolated_i is ignored in this state.
- **WAKE** (1,1,0)
  - Counts SettleCycles, then -> RUN.
  - gate_req_i is ignored until RUN is reached. A re-asserted request is acted on from RUN on the following cycle.
- **Blocked behaviour:** while blocked, the cluster stays in RUN even if gate_req_i is high. Software must drop the request for at least one cycle to retry.
- **Reset:** all FSMs in RUN, counters 0, blocked 0. Outputs: isolate_o=0, clk_en_o=all 1, gated_o=0, timeout_o=0.
- **Reset asserted mid-sequence** (any state): outputs return to reset values asynchronously. The clock is re-enabled and isolation is dropped immediately.

## Timing

- **Gate request:** gate_req_i sampled high at edge t in RUN -> isolate_o=1 from t+1.
- **Drain acknowledge:** isolated_i sampled high at edge t in ISOLATE -> clk_en_o=0 and gated_o=1 from t+1.
- **Minimum gate latency:** request to clock off is 2 cycles, when isolated_i is already high.
- **Timeout:**
  - ISOLATE is occupied for exactly TimeoutCycles cycles before abort.
  - timeout_o is high for one cycle, coinciding with the first RUN cycle (isolate_o=0).
- **Release:** gate_req_i sampled low at t in GATED -> clk_en_o=1 from t+1. isolate_o stays 1 for SettleCycles cycles (t+1 .. t+SettleCycles) and falls at t+SettleCycles+1.
- **Withdrawal:** gate_req_i sampled low at t in ISOLATE -> isolate_o=0 from t+1. The clock is never stopped.
- **Glitch-free enable:** clk_en_o is a flop output, so no combinational glitches reach the gate cell.

## Test plan

- **Normal gate/ungate:** reset; gate_req_i[2]=1, isolated_i[2] tied 1.
  - isolate_o[2]=1 one cycle later; clk_en_o[2]=0 and gated_o[2]=1 two cycles after the request.
  - Drop the request: clk_en_o[2]=1 the next cycle; isolate_o[2]=0 exactly 4 cycles later (SettleCycles=4).
  - Other clusters unchanged.
- **Delayed drain:** isolated_i[0] rises 10 cycles after isolate_o[0] -> clk_en_o[0]=0 on the following cycle; timeout_o[0] never pulses.
- **Timeout (TimeoutCycles=16):** isolated_i[1] held 0.
  - Exactly 16 cycles after isolate_o[1] rises: isolate_o[1]=0, timeout_o[1] pulses for 1 cycle, clk_en_o[1] stays 1.
  - With the request held high, the cluster remains in RUN.
  - Drop the request for 1 cycle and re-raise it -> isolate_o[1]=1 again.
- **Withdrawal and simultaneous events:**
  - Drop gate_req_i in ISOLATE on the same cycle isolated_i rises -> back to RUN, clk_en_o never 0.
  - isolated_i rises on the timeout cycle -> GATED, no timeout_o pulse.
- **Reset mid-sequence:**
  - Assert rst_ni low while cluster 3 is in GATED and cluster 4 is in WAKE -> all clk_en_o=1, all isolate_o=0 and gated_o=0 asynchronously, before the next clock edge.
  - After release, a fresh request on either cluster sequences normally.

Source files
------------

// File: rtl/chimera_clu_gate_seq.sv
// rtl/chimera_clu_gate_seq.sv - per-cluster clock-gate sequencer (isolate, drain, gate, settle, release)
module chimera_clu_gate_seq #(
  parameter int unsigned NumClusters   = 5,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned SettleCycles  = 4
) (
  input  logic                   soc_clk_i,
  input  logic                   rst_ni,
  input  logic [NumClusters-1:0] gate_req_i,
  input  logic [NumClusters-1:0] isolated_i,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] gated_o,
  output logic [NumClusters-1:0] timeout_o
);

  localparam int unsigned CntMax = (TimeoutCycles > SettleCycles) ? TimeoutCycles : SettleCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] SettleLast  = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] CntSat      = CntW'(CntMax);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StIsolate = 2'd1,
    StGated   = 2'd2,
    StWake    = 2'd3
  } state_e;

  for (genvar c = 0; c < NumClusters; c++) begin : g_cluster
    state_e          r_state;
    state_e          w_state_next;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;
    logic            r_blocked;
    logic            w_blocked_next;
    logic            w_timeout;
    logic            r_isolate;
    logic            r_clk_en;
    logic            r_gated;
    logic            r_timeout;
    logic            w_isolate;
    logic            w_clk_en;
    logic            w_gated;

    always_ff @(posedge soc_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state   <= StRun;
        r_cnt     <= '0;
        r_blocked <= 1'b0;
        r_isolate <= 1'b0;
        r_clk_en  <= 1'b1;
        r_gated   <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        r_state   <= w_state_next;
        r_cnt     <= w_cnt_next;
        r_blocked <= w_blocked_next;
        r_isolate <= w_isolate;
        r_clk_en  <= w_clk_en;
        r_gated   <= w_gated;
        r_timeout <= w_timeout;
      end
    end

    always_comb begin
      w_state_next   = r_state;
      w_timeout      = 1'b0;
      w_blocked_next = r_blocked & gate_req_i[c];

      unique case (r_state)
        StRun: begin
          if (gate_req_i[c] && !r_blocked) w_state_next = StIsolate;
        end
        StIsolate: begin
          // Withdrawal beats drain-ack, and drain-ack beats the timeout.
          if (!gate_req_i[c]) begin
            w_state_next = StRun;
          end else if (isolated_i[c]) begin
            w_state_next = StGated;
          end else if (r_cnt == TimeoutLast) begin
            w_state_next   = StRun;
            w_timeout      = 1'b1;
            w_blocked_next = 1'b1;
          end
        end
        StGated: begin
          if (!gate_req_i[c]) w_state_next = StWake;
        end
        StWake: begin
          if (r_cnt == SettleLast) w_state_next = StRun;
        end
        default: w_state_next = StRun;
      endcase
    end

    always_comb begin
      w_cnt_next = r_cnt;
      if (w_state_next != r_state) begin
        w_cnt_next = '0;
      end else if ((r_state == StIsolate || r_state == StWake) && r_cnt != CntSat) begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end

    // Outputs are decoded from the next state and registered so the gate enable is a clean flop.
    always_comb begin
      w_isolate = 1'b0;
      w_clk_en  = 1'b1;
      w_gated   = 1'b0;
      unique case (w_state_next)
        StRun: begin
          w_isolate = 1'b0;
        end
        StIsolate: begin
          w_isolate = 1'b1;
        end
        StGated: begin
          w_isolate = 1'b1;
          w_clk_en  = 1'b0;
          w_gated   = 1'b1;
        end
        StWake: begin
          w_isolate = 1'b1;
        end
        default: begin
          w_isolate = 1'b0;
        end
      endcase
    end

    assign isolate_o[c] = r_isolate;
    assign clk_en_o[c]  = r_clk_en;
    assign gated_o[c]   = r_gated;
    assign timeout_o[c] = r_timeout;
  end

endmodule
